score_segment_gen: RTL and testbench
====================================

SCORE_SEGMENT_GEN -- requirements
Module: score_segment_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept an input change (10 ms at 25 MHz).
REQ-002 Parameter MAX_SCORE, default 9, highest displayable score; legal range 1..9.
REQ-003 Parameter WRAP, default 1, 1 = wrap to 0 after MAX_SCORE, 0 = saturate at MAX_SCORE.
REQ-004 Reset is iRST_n, asynchronous, active-low; the clock is iVGA_CLK.
REQ-005 iVGA_CLK  input  1  pixel clock, sole clock domain.
REQ-006 iRST_n  input  1  asynchronous active-low reset.
REQ-007 iScoreEvt  input  1  raw score pushbutton, active-low, asynchronous to iVGA_CLK, may bounce.
REQ-008 iClear  input  1  synchronous active-high score clear.
REQ-009 iVS  input  1  vertical sync from the sync generator, active-low.
REQ-010 oScoreSegment  output  7  active-low segments: bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 centre; feeds the VGA controller score overlay.
REQ-011 oScore  output  4  current binary score.
REQ-012 oRollover  output  1  one-cycle pulse on wrap from MAX_SCORE to 0.

Function
REQ-013 iScoreEvt shall pass through a 2-flop synchronizer, with both flops reset to 1.
REQ-014 The debouncer shall hold a stable level, reset to 1, and a counter, reset to 0.
REQ-015 Debounce counting: synchronized input != stable increments the counter; at count DEBOUNCE_CYCLES-1 the stable level takes the input and the counter clears; input == stable clears the counter.
REQ-016 A press pulse shall assert for exactly one cycle, the cycle after the stable level goes 1->0; release generates nothing.
REQ-017 Press with score < MAX_SCORE: score increments by 1 on the next clock.
REQ-018 Press with score == MAX_SCORE and WRAP=1: score becomes 0 and oRollover pulses for one cycle, in the same cycle.
REQ-019 Press with score == MAX_SCORE and WRAP=0: score holds and there is no oRollover pulse.
REQ-020 iClear has priority over a press in the same cycle: score goes to 0, no oRollover, the press is discarded.
REQ-021 oScore shall be the registered score, with no extra latency.
REQ-022 iVS shall be registered once; a frame edge is previous=1, current=0.
REQ-023 oScoreSegment shall update only on the clock after a frame edge, loading decode(oScore) as sampled on the edge cycle; it holds at all other times (no mid-frame tearing).
REQ-024 A score change coincident with the edge cycle shall be displayed at the next frame edge.
REQ-025 Decode (bits 6..0, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; 10..15 = 7F (blank).
REQ-026 If iVS is held constant, oScoreSegment shall never change.

Reset
REQ-027 Asserting iRST_n low shall immediately force: score 0, oRollover 0, oScoreSegment 7'h40, synchronizer and stable level 1, debounce counter 0, registered iVS 1.
REQ-028 A reset asserted mid-debounce shall discard the partial count; no press shall follow deassertion unless the input is held low for a fresh DEBOUNCE_CYCLES.
REQ-029 Reset deassertion shall be synchronized to iVGA_CLK before use.

Structure
REQ-030 A shared package shall hold the 7-segment decode constants (SEG_0..SEG_9, SEG_BLANK), the segment-bit index names and the DEBOUNCE_CYCLES default.
REQ-031 Synchronizer plus debouncer plus press-pulse logic shall be one sub-module, button_debounce, reusable for the mUp/mDown/mLeft/mRight pads.
REQ-032 All sequential logic is in the iVGA_CLK domain; there are no latches and no derived clocks.

Verification (DEBOUNCE_CYCLES=16 for simulation)
REQ-033 iScoreEvt low for 16+ cycles, then high, repeated 3 times, with a frame edge after each -> oScore 1, 2, 3 and oScoreSegment 79, 24, 30.
REQ-034 iScoreEvt toggles every 5 cycles for 100 cycles -> no press, oScore unchanged.
REQ-035 10 presses with WRAP=1 -> oScore 9 then 0, exactly one oRollover pulse, oScoreSegment 40 after the next edge; with WRAP=0 the score stays 9 and there is no pulse.
REQ-036 Press accepted with no frame edge for 1000 cycles -> oScore changes, oScoreSegment unchanged until the edge, updated on the cycle after the edge.
REQ-037 Press pulse and iClear in the same cycle -> oScore 0, no oRollover.
REQ-038 Reset pulse at count 10 of the debounce, input stays low -> oScoreSegment 40 during reset, first press 16 cycles after the synchronized deassertion.

Source files
------------

// File: rtl/score_segment_gen_pkg.sv
// Shared constants for the score display path: 7-segment encodings,
// segment bit positions and the default debounce length.
package score_segment_gen_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

    typedef enum logic [2:0] {
        SEG_TOP         = 3'd0,
        SEG_UPPER_RIGHT = 3'd1,
        SEG_LOWER_RIGHT = 3'd2,
        SEG_BOTTOM      = 3'd3,
        SEG_LOWER_LEFT  = 3'd4,
        SEG_UPPER_LEFT  = 3'd5,
        SEG_CENTRE      = 3'd6
    } seg_bit_e;

    // Active-low: a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_segment_gen_button.sv
// Pushbutton conditioner: 2-flop synchronizer, counting debouncer and a
// single-cycle press pulse on each accepted 1->0 transition.
module button_debounce
    import score_segment_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    output logic press
);

    localparam int unsigned COUNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         sync;
    logic               stable;
    logic               stable_q;
    logic [COUNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '1;
            stable   <= 1'b1;
            stable_q <= 1'b1;
            count    <= '0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], button_n};
            stable_q <= stable;
            press    <= stable_q & ~stable;
            // Any sample that agrees with the stable level restarts the window.
            if (sync[1] != stable) begin
                if (count == COUNT_LAST) begin
                    stable <= sync[1];
                    count  <= '0;
                end else begin
                    count <= count + COUNT_W'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/score_segment_gen.sv
// Score counter driven by a debounced pushbutton, with a 7-segment register
// that only reloads at frame start so the overlay never tears mid-frame.
module score_segment_gen
    import score_segment_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned MAX_SCORE       = 9,
    parameter bit          WRAP            = 1'b1
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iScoreEvt,
    input  logic       iClear,
    input  logic       iVS,
    output logic [6:0] oScoreSegment,
    output logic [3:0] oScore,
    output logic       oRollover
);

    localparam logic [3:0] SCORE_TOP = 4'(MAX_SCORE);

    logic [1:0] rst_pipe;
    logic       rst_n;
    logic       press;
    logic       vs_q;
    logic       frame_edge;

    // Assertion passes straight through; release is aligned to the clock.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) rst_pipe <= '0;
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_score_button (
        .clk     (iVGA_CLK),
        .rst_n   (rst_n),
        .button_n(iScoreEvt),
        .press   (press)
    );

    always_ff @(posedge iVGA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            oScore    <= '0;
            oRollover <= 1'b0;
        end else begin
            oRollover <= 1'b0;
            if (iClear) begin
                oScore <= '0;
            end else if (press) begin
                if (oScore < SCORE_TOP) begin
                    oScore <= oScore + 4'd1;
                end else if (WRAP) begin
                    oScore    <= '0;
                    oRollover <= 1'b1;
                end
            end
        end
    end

    assign frame_edge = vs_q & ~iVS;

    always_ff @(posedge iVGA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b1;
            oScoreSegment <= SEG_0;
        end else begin
            vs_q <= iVS;
            if (frame_edge) oScoreSegment <= seg_decode(oScore);
        end
    end

endmodule

// File: tb/tb_score_segment_gen.sv
// Bench for score_segment_gen: two instances (wrap and saturate) share stimulus
// and are checked every cycle against a run-length behavioural model.
module tb_score_segment_gen;

    localparam int unsigned N    = 16;
    localparam int          MAXS = 9;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt   = 1'b1;
    logic       clr   = 1'b0;
    logic       vs    = 1'b1;
    logic [6:0] seg   [2];
    logic [3:0] score [2];
    logic       roll  [2];

    int tests = 0;
    int fails = 0;
    int roll_cnt [2];
    bit done = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Behavioural model state
    int         run;
    int         rst_age;
    logic       stable_m;
    logic [1:0] sync_m;
    logic       fell_q;
    logic       press_m;
    logic       vs_m;
    int         m_score [2];
    logic       m_roll  [2];
    logic [6:0] m_seg   [2];

    score_segment_gen #(.DEBOUNCE_CYCLES(N), .MAX_SCORE(MAXS), .WRAP(1'b1)) dut_wrap (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iScoreEvt(evt), .iClear(clr), .iVS(vs),
        .oScoreSegment(seg[0]), .oScore(score[0]), .oRollover(roll[0]));

    score_segment_gen #(.DEBOUNCE_CYCLES(N), .MAX_SCORE(MAXS), .WRAP(1'b0)) dut_sat (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iScoreEvt(evt), .iClear(clr), .iVS(vs),
        .oScoreSegment(seg[1]), .oScore(score[1]), .oRollover(roll[1]));

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; stable_m = 1'b1; sync_m = 2'b11; fell_q = 1'b0; press_m = 1'b0; vs_m = 1'b1;
        for (int w = 0; w < 2; w++) begin
            m_score[w] = 0; m_roll[w] = 1'b0; m_seg[w] = 7'h40;
        end
    endtask

    task automatic model_step();
        logic synced;
        logic fell;
        logic press_now;
        synced = sync_m[1];
        sync_m = {sync_m[0], evt};
        fell   = 1'b0;
        // Stable level follows only after N consecutive disagreeing samples.
        if (synced != stable_m) begin
            run++;
            if (run == N) begin
                fell     = !synced;
                stable_m = synced;
                run      = 0;
            end
        end else begin
            run = 0;
        end
        press_now = press_m;
        press_m   = fell_q;
        fell_q    = fell;
        for (int w = 0; w < 2; w++) begin
            if (vs_m && !vs) m_seg[w] = seg_tab[m_score[w]];
            m_roll[w] = 1'b0;
            if (clr) m_score[w] = 0;
            else if (press_now) begin
                if (m_score[w] < MAXS) m_score[w] = m_score[w] + 1;
                else if (w == 0) begin
                    m_score[w] = 0;
                    m_roll[w]  = 1'b1;
                end
            end
        end
        vs_m = vs;
    endtask

    initial begin
        model_reset();
        rst_age = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                rst_age = 0;
            end else if (rst_age < 2) begin
                rst_age++;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        roll_cnt[0] = 0; roll_cnt[1] = 0;
        @(negedge clk);
        while (!done) begin
            for (int w = 0; w < 2; w++) begin
                check(w == 0 ? "score_wrap" : "score_sat", int'(score[w]), m_score[w]);
                check(w == 0 ? "rollover_wrap" : "rollover_sat", int'(roll[w]), int'(m_roll[w]));
                check(w == 0 ? "segment_wrap" : "segment_sat", int'(seg[w]), int'(m_seg[w]));
                if (roll[w]) roll_cnt[w]++;
            end
            @(negedge clk);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_once();
        evt = 1'b0; tick(24);
        evt = 1'b1; tick(24);
    endtask

    task automatic frame();
        vs = 1'b0; tick(3);
        vs = 1'b1; tick(3);
    endtask

    initial begin
        logic [6:0] lit [3];
        int first;
        bit hit;
        int evt_left;
        int vs_left;
        lit[0] = 7'h79; lit[1] = 7'h24; lit[2] = 7'h30;

        tick(4);
        check("reset_score", int'(score[0]), 0);
        check("reset_segment", int'(seg[0]), 'h40);
        check("reset_rollover", int'(roll[0]), 0);
        rst_n = 1'b1;
        tick(4);

        for (int k = 1; k <= 3; k++) begin
            press_once();
            frame();
            check("press_score", int'(score[0]), k);
            check("press_segment", int'(seg[0]), int'(lit[k-1]));
        end

        for (int i = 0; i < 20; i++) begin
            evt = ~evt; tick(5);
        end
        tick(24);
        check("bounce_ignored", int'(score[0]), 3);

        clr = 1'b1; tick(1); clr = 1'b0; tick(2);
        frame();
        check("clear_score", int'(score[0]), 0);

        for (int i = 0; i < 9; i++) press_once();
        check("nine_wrap", int'(score[0]), 9);
        check("nine_sat", int'(score[1]), 9);
        roll_cnt[0] = 0; roll_cnt[1] = 0;
        press_once();
        check("tenth_wrap", int'(score[0]), 0);
        check("tenth_sat", int'(score[1]), 9);
        check("rollover_count_wrap", roll_cnt[0], 1);
        check("rollover_count_sat", roll_cnt[1], 0);
        frame();
        check("rollover_segment_wrap", int'(seg[0]), 'h40);
        check("rollover_segment_sat", int'(seg[1]), 'h10);

        press_once();
        tick(1000);
        check("noedge_score", int'(score[0]), 1);
        check("noedge_segment", int'(seg[0]), 'h40);
        vs = 1'b0; tick(1);
        check("edge_segment", int'(seg[0]), 'h79);
        vs = 1'b1; tick(3);

        for (int i = 0; i < 8; i++) press_once();
        check("at_max_wrap", int'(score[0]), 9);
        roll_cnt[0] = 0; roll_cnt[1] = 0;
        hit = 1'b0;
        evt = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick(1);
            if (press_m) begin
                hit = 1'b1;
                clr = 1'b1; tick(1); clr = 1'b0;
            end
        end
        evt = 1'b1; tick(24);
        check("clear_press_seen", int'(hit), 1);
        check("clear_press_wrap", int'(score[0]), 0);
        check("clear_press_sat", int'(score[1]), 0);
        check("clear_press_rollover", roll_cnt[0], 0);

        evt = 1'b0; tick(12);
        rst_n = 1'b0; tick(1);
        check("midreset_segment", int'(seg[0]), 'h40);
        check("midreset_score", int'(score[0]), 0);
        tick(2);
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (first == 0 && score[0] == 4'd1) first = i;
        end
        check("midreset_press_latency", first, 22);
        evt = 1'b1; tick(24);

        evt_left = 0; vs_left = 0;
        repeat (4000) begin
            if (evt_left == 0) begin
                evt = 1'($urandom_range(0, 1));
                evt_left = int'($urandom_range(1, 40));
            end
            evt_left--;
            if (vs_left == 0) begin
                vs = ~vs;
                vs_left = vs ? int'($urandom_range(20, 120)) : int'($urandom_range(1, 4));
            end
            vs_left--;
            clr = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        clr = 1'b0;

        done = 1'b1;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
